// File: rtl/banco_pkg.sv
// Shared types and defaults for the parametrised register bank.
// Imported by the bank top level and its read ports.
package banco_pkg;

    typedef enum logic {IDLE, CLEAR} banco_state_t;

    localparam int W_DEF = 8;
    localparam int A_DEF = 4;

endpackage

// File: rtl/banco_read_port.sv
// One registered read port: zero for x0, forward the committing write,
// report zero for the word the sweep is clearing, else read storage.
module banco_read_port
    import banco_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [A-1:0]               addr_i,
    input  logic                       wr_en_i,
    input  logic [A-1:0]               wr_addr_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       clr_en_i,
    input  logic [A-1:0]               clr_addr_i,
    input  logic [(1<<A)-1:0][W-1:0]   bank_i,
    output logic [W-1:0]               data_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = '0;
        if (addr_i == '0) begin
            data_d = '0;
        end else if (wr_en_i && wr_addr_i == addr_i) begin
            data_d = wr_data_i;
        end else if (clr_en_i && clr_addr_i == addr_i) begin
            data_d = '0;
        end else begin
            data_d = bank_i[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/banco_registro_param.sv
// 2^A x W register bank, x0 hardwired to zero, two registered read
// ports and a one-word-per-cycle clear sweep.
module banco_registro_param
    import banco_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [A-1:0] addr_rd,
    input  logic [W-1:0] data_in,
    input  logic [A-1:0] addr_rs1,
    input  logic [A-1:0] addr_rs2,
    input  logic         clr,
    output logic [W-1:0] rs1,
    output logic [W-1:0] rs2,
    output logic         busy
);

    localparam int DEPTH = 1 << A;
    localparam logic [A-1:0] LAST = {A{1'b1}};

    banco_state_t state_q, state_d;
    logic [A-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0][W-1:0] bank_q;
    logic wr_en;
    logic clr_en;

    // clr has priority over a same-cycle write; writes in CLEAR are lost
    assign wr_en = we && (state_q == IDLE) && !clr
                   && (addr_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = A'(1);
                end
            end
            CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + A'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == CLEAR);
        clr_en = (state_q == CLEAR);
    end

    // entry 0 is never targeted: wr_en excludes it and ptr starts at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            if (wr_en) begin
                bank_q[addr_rd] <= data_in;
            end
            if (clr_en) begin
                bank_q[ptr_q] <= '0;
            end
        end
    end

    banco_read_port #(.W(W), .A(A)) u_rp1 (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_rs1),
        .wr_en_i    (wr_en),
        .wr_addr_i  (addr_rd),
        .wr_data_i  (data_in),
        .clr_en_i   (clr_en),
        .clr_addr_i (ptr_q),
        .bank_i     (bank_q),
        .data_o     (rs1)
    );

    banco_read_port #(.W(W), .A(A)) u_rp2 (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_rs2),
        .wr_en_i    (wr_en),
        .wr_addr_i  (addr_rd),
        .wr_data_i  (data_in),
        .clr_en_i   (clr_en),
        .clr_addr_i (ptr_q),
        .bank_i     (bank_q),
        .data_o     (rs2)
    );

endmodule

// File: tb/tb_banco_registro_param.sv
// Directed bench for banco_registro_param: a W=8/A=4 bank and a
// W=1/A=1 corner instance sharing one clock.
module tb_banco_registro_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [3:0] addr_rd = '0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_rs1 = '0;
    logic [3:0] addr_rs2 = '0;
    logic       clr = 1'b0;
    logic [7:0] rs1;
    logic [7:0] rs2;
    logic       busy;

    logic       s_rst = 1'b1;
    logic       s_we = 1'b0;
    logic [0:0] s_addr_rd = '0;
    logic [0:0] s_data_in = '0;
    logic [0:0] s_addr_rs1 = '0;
    logic [0:0] s_addr_rs2 = '0;
    logic       s_clr = 1'b0;
    logic [0:0] s_rs1;
    logic [0:0] s_rs2;
    logic       s_busy;

    int n_cmp = 0;
    int n_bad = 0;

    banco_registro_param #(.W(8), .A(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr_rd  (addr_rd),
        .data_in  (data_in),
        .addr_rs1 (addr_rs1),
        .addr_rs2 (addr_rs2),
        .clr      (clr),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy     (busy)
    );

    banco_registro_param #(.W(1), .A(1)) dut_s (
        .clk      (clk),
        .rst      (s_rst),
        .we       (s_we),
        .addr_rd  (s_addr_rd),
        .data_in  (s_data_in),
        .addr_rs1 (s_addr_rs1),
        .addr_rs2 (s_addr_rs2),
        .clr      (s_clr),
        .rs1      (s_rs1),
        .rs2      (s_rs2),
        .busy     (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1;
        addr_rd = a;
        data_in = d;
        tick();
        we = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 1; i < 16; i++) wr(4'(i), base + 8'(i));
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr_rs1 = 4'(i);
            addr_rs2 = 4'(15 - i);
            tick();
            chk({tag, "_rs1"}, 32'(rs1), 32'h0);
            chk({tag, "_rs2"}, 32'(rs2), 32'h0);
        end
    endtask

    initial begin
        int n;
        tick();
        rst = 1'b0;
        s_rst = 1'b0;

        // garbage, then reset
        fill(8'hC0);
        addr_rs1 = 4'd3;
        addr_rs2 = 4'd4;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rs1", 32'(rs1), 32'h0);
        chk("rst_rs2", 32'(rs2), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        read_all_zero("rst_read");

        // write/read and x0
        wr(4'd3, 8'hA5);
        wr(4'd0, 8'hFF);
        addr_rs1 = 4'd3;
        addr_rs2 = 4'd0;
        tick();
        chk("rd3", 32'(rs1), 32'hA5);
        chk("rd0", 32'(rs2), 32'h00);

        // forwarding
        addr_rs1 = 4'd7;
        addr_rs2 = 4'd7;
        wr(4'd7, 8'h3C);
        chk("fwd_rs1", 32'(rs1), 32'h3C);
        chk("fwd_rs2", 32'(rs2), 32'h3C);
        tick();
        chk("stored7", 32'(rs1), 32'h3C);

        // clear sweep with dropped write on last sweep cycle
        fill(8'h10);
        addr_rs1 = 4'd15;
        addr_rs2 = 4'd5;
        tick();
        chk("pre15", 32'(rs1), 32'h1F);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 15) begin
                we = 1'b1;
                addr_rd = 4'd5;
                data_in = 8'h11;
            end
            tick();
            we = 1'b0;
        end
        chk("busy_len", 32'(n), 32'd15);
        chk("drop5", 32'(rs2), 32'h0);
        read_all_zero("clr_read");

        // clr/we collision, then reset in the 4th sweep cycle
        fill(8'h20);
        addr_rs1 = 4'd2;
        addr_rs2 = 4'd9;
        clr = 1'b1;
        we = 1'b1;
        addr_rd = 4'd2;
        data_in = 8'h77;
        tick();
        clr = 1'b0;
        we = 1'b0;
        chk("col_busy", 32'(busy), 32'h1);
        chk("col_nofwd", 32'(rs1), 32'h22);
        chk("col_rs2", 32'(rs2), 32'h29);
        tick();
        chk("sw_rd2", 32'(rs1), 32'h22);
        tick();
        chk("sw_zero2", 32'(rs1), 32'h0);
        tick();
        addr_rs2 = 4'd5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        tick();
        chk("abort_busy2", 32'(busy), 32'h0);
        chk("abort_rs2", 32'(rs2), 32'h0);
        read_all_zero("abort_read");

        // W=1, A=1 corner
        s_we = 1'b1;
        s_addr_rd = 1'b1;
        s_data_in = 1'b1;
        tick();
        s_we = 1'b0;
        s_addr_rs1 = 1'b1;
        s_addr_rs2 = 1'b0;
        tick();
        chk("s_rd1", 32'(s_rs1), 32'h1);
        chk("s_rd0", 32'(s_rs2), 32'h0);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        n = 0;
        while (s_busy && n < 10) begin
            n++;
            tick();
        end
        chk("s_busy_len", 32'(n), 32'd1);
        tick();
        chk("s_cleared", 32'(s_rs1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/banco_registro_param.md
# banco_registro_param

Parametrised register bank: 2^A words of W bits, one write port and two read ports. Register 0 is hardwired to zero. Reads are registered with write-to-read forwarding, and a clear sequencer zeroes the bank one word per cycle without a reset. It sits between the datapath's operand-select stage and the ALU, where rs1/rs2 feed the ALU inputs one cycle after the addresses are presented.

## Interface
Parameters:
- W, 8, data word width in bits (≥1)
- A, 4, address width; DEPTH = 2^A words (A ≥ 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write enable for the current cycle
- addr_rd  input  A  write address
- data_in  input  W  write data
- addr_rs1  input  A  read address, port 1
- addr_rs2  input  A  read address, port 2
- clr  input  1  one-cycle request to start a clear sweep
- rs1  output  W  read data, port 1 (registered)
- rs2  output  W  read data, port 2 (registered)
- busy  output  1  high while the clear sweep runs

## Operation
- Storage: registro[0..DEPTH-1]. Entry 0 is never written and always reads 0.
- Write: if we=1 in IDLE, no clr, and addr_rd≠0, then registro[addr_rd] ← data_in at the clock edge. A write to address 0 is discarded.
- Read: each port captures its word into its output flop at the edge. The source is:
  - 0 if the address is 0;
  - otherwise data_in if a write to the same address is committing in this cycle (forwarding);
  - otherwise 0 if the sweep is zeroing that address in this cycle;
  - otherwise registro[addr].
- FSM states: IDLE, CLEAR.
  - IDLE: clr=1 moves to CLEAR with ptr←1. When clr and we are both high, clr wins and the write is dropped.
  - CLEAR: registro[ptr] ← 0 and ptr←ptr+1 each cycle. When ptr=DEPTH-1 is zeroed, the FSM returns to IDLE.
  - In CLEAR, we is ignored and the write is lost, not queued. clr is ignored.
  - Reads continue during CLEAR and return current contents, subject to the rules above.
- busy = (state==CLEAR).
- ptr is A bits wide and never wraps. The sweep ends at DEPTH-1.
- A=1 case: the sweep lasts exactly one cycle (address 1 only).

## Timing
- Reset (rst=1 at an edge): all registro entries 0, rs1=rs2=0, busy=0, state=IDLE, ptr=0. rst overrides we, clr and an in-progress sweep in the same cycle.
- Reset mid-sweep aborts it. The next cycle is IDLE with the bank fully zero.
- Read latency: 1 cycle. An address presented at edge k gives data visible after edge k.
- Write-to-read through storage: a write at edge k is visible to a read at edge k+1. Forwarding makes a same-cycle read return the new data after edge k.
- Clear: clr sampled at edge k puts busy high after edge k. busy stays high for DEPTH-1 cycles and drops after the edge that zeroes DEPTH-1.
- Outputs are registered and never combinationally dependent on inputs.

## Structure
- Package banco_pkg holds:
  - typedef enum logic {IDLE, CLEAR} banco_state_t;
  - default constants W_DEF=8, A_DEF=4.
- One sub-module, banco_read_port: per-port address decode, zero/forward/clear-mux and output flop. It is instantiated twice.
- The top level holds the storage array, the write logic, the FSM and ptr.

## Test plan
- Reset: drive rst=1 for 1 cycle with prior garbage in the bank → rs1=rs2=0, busy=0. Reading every address returns 0.
- Write/read and x0: write 0xA5 to addr 3 and 0xFF to addr 0; read rs1=3, rs2=0 → rs1=0xA5, rs2=0x00.
- Forwarding: same cycle as writing 0x3C to addr 7, set addr_rs1=addr_rs2=7 → both outputs 0x3C one cycle later.
- Clear sweep (W=8, A=4): fill addrs 1–15 with nonzero values, pulse clr → busy high exactly 15 cycles. A write of 0x11 to addr 5 during the sweep is dropped. All addrs then read 0.
- clr vs we collision: pulse clr with we=1, addr_rd=2, data 0x77 → sweep starts and addr 2 reads 0 afterwards. Then rst at the 4th sweep cycle → busy=0 next cycle and all addrs read 0.
- Parameter corner: W=1, A=1 → write 1 to addr 1 and read back 1. clr gives busy for exactly 1 cycle.
